ram_access_sequencer: RTL

- Upstream front end for the RAM controller.
- Accepts byte read/write requests from the CPU bus over a valid/ready handshake and buffers them in a small request FIFO.
- Sequences each request into the controller's timing: the address is latched one cycle, then the bank select, write strobe or data-out mux is applied in the following cycle.
- Returns read data and error status on a response pulse. Out-of-range accesses are trapped here and never reach the SRAM.

---
 rtl/ram_access_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ram_access_sequencer.sv
// CPU-side front end for the RAM controller: a request FIFO feeding an address/strobe sequencer.
// Define RAM_SEQ_POSTED_WR_EN for posted writes (no write responses, sticky out-of-range flag).
module ram_access_sequencer #(
    parameter int unsigned RAM_SIZE     = 4096,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter logic [7:0]  OOR_READ_VAL = 8'hFF
) (
    input  logic        clk_i,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        resp_valid,
    output logic [7:0]  resp_rdata,
    output logic        resp_err,
    output logic [15:0] requested_addr,
    output logic        WEb_ram,
    output logic [7:0]  bus_in,
    output logic        ram_enabled,
    input  logic [7:0]  bus_out
`ifdef RAM_SEQ_POSTED_WR_EN
    ,
    output logic        wr_err_sticky
`endif
);
    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam logic [16:0] RAM_LIMIT = 17'(RAM_SIZE);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_CAP, WR_SETUP, WR_STROBE} state_t;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } req_t;

    state_t      state, state_nxt;
    req_t        fifo_mem [FIFO_DEPTH];
    req_t        head;
    logic [PW:0] wr_ptr, rd_ptr;
    logic [15:0] cur_addr;
    logic        fifo_empty, fifo_full, push, pop, in_range;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty     = (wr_ptr == rd_ptr);
    assign fifo_full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign req_ready      = !rst && !fifo_full;
    assign push           = req_valid && req_ready;
    assign head           = fifo_mem[rd_ptr[PW-1:0]];
    assign requested_addr = cur_addr;
    assign in_range       = ({1'b0, cur_addr} < RAM_LIMIT);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        ram_enabled = 1'b0;
        WEb_ram     = 1'b1;
        unique case (state)
            IDLE: ;
            RD_ADDR: begin
                ram_enabled = in_range;
                state_nxt   = RD_CAP;
            end
            RD_CAP: ram_enabled = in_range;
            WR_SETUP: begin
                ram_enabled = in_range;
                state_nxt   = WR_STROBE;
            end
            WR_STROBE: begin
                ram_enabled = in_range;
                WEb_ram     = !in_range;
            end
            default: state_nxt = IDLE;
        endcase
        // Only states that finish (or never started) an access may fetch the next request.
        if (state == IDLE || state == RD_CAP || state == WR_STROBE) begin
            if (!fifo_empty) begin
                pop       = 1'b1;
                state_nxt = head.we ? WR_SETUP : RD_ADDR;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    // NOTE: FIFO storage has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr[PW-1:0]] <= {req_we, req_addr, req_wdata};
        end
    end

    // NOTE: all sequential state uses non-blocking assignments to avoid evaluation-order races.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cur_addr   <= '0;
            bus_in     <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
`ifdef RAM_SEQ_POSTED_WR_EN
            wr_err_sticky <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            resp_valid <= 1'b0;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                cur_addr <= head.addr;
                if (head.we) bus_in <= head.wdata;
            end
            if (state == RD_CAP) begin
                resp_valid <= 1'b1;
                resp_rdata <= in_range ? bus_out : OOR_READ_VAL;
                resp_err   <= !in_range;
            end
            if (state == WR_STROBE) begin
`ifdef RAM_SEQ_POSTED_WR_EN
                if (!in_range) wr_err_sticky <= 1'b1;
`else
                resp_valid <= 1'b1;
                resp_rdata <= 8'h00;
                resp_err   <= !in_range;
`endif
            end
        end
    end

endmodule
